pi_mem_arbiter: RTL and testbench
=================================

Name: pi_mem_arbiter

Overview:
- Shares the single s2 port of the 128x32 Nios/Pi mailbox RAM between two requesters: requester A (SPI slave bridge, Raspberry Pi side) and requester B (FPGA-side logic, e.g. accelerometer/status snapshot writer).
- Sits in DE0_NANO between the requesters and the mem_nios_pi_s2_* pins of Nios_sopc. It replaces the direct drive of that port by the data_* exports.
- Round-robin arbitration, one access in flight at a time, fixed read latency handling, registered outputs.

Parameters:
- AW, 7, RAM word-address width.
- DW, 32, data width.
- RD_LAT, 1, RAM read latency in cycles from address sampled to readdata valid (1..3).

Ports:
- iCLK  in  1  system clock (CLOCK_50)
- iRSTN  in  1  asynchronous active-low reset
- a_req  in  1  A requests an access; held with a_we/a_addr/a_wdata stable until a_gnt
- a_we  in  1  1 = write, 0 = read
- a_addr  in  AW  word address
- a_wdata  in  DW  write data
- a_gnt  out  1  one-cycle pulse: A's command is on the RAM port this cycle
- a_rvalid  out  1  one-cycle pulse: a_rdata valid (reads only)
- a_rdata  out  DW  read data, held until next A read completes
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- mem_addr  out  AW  to mem_nios_pi_s2_address
- mem_we  out  1  to mem_nios_pi_s2_write
- mem_wdata  out  DW  to mem_nios_pi_s2_writedata
- mem_rdata  in  DW  from mem_nios_pi_s2_readdata
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, iCLK. Reset is asynchronous, active-low on iRSTN. All state and outputs are registered.
- Reset values:
  - state = IDLE, last = B (A wins the first tie).
  - mem_addr = 0, mem_we = 0, mem_wdata = 0.
  - a_gnt/b_gnt/a_rvalid/b_rvalid = 0, a_rdata/b_rdata = 0, busy = 0.
- States: IDLE, ISSUE, RWAIT, CAPTURE.
- IDLE, cycle T:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the winner is the requester that is not `last`.
  - At the T edge: register the winner's addr/wdata/we into mem_*, set gnt_winner = 1, set last = winner, go to ISSUE.
- ISSUE, cycle T+1:
  - The command is on the port and gnt is high. The RAM samples the command at the end of T+1.
  - At the edge: mem_we <= 0 and gnt <= 0.
  - Write: go to IDLE, so a new arbitration happens at T+2.
  - Read: load cnt = RD_LAT-1 and go to RWAIT (go straight to CAPTURE if RD_LAT = 1).
- RWAIT: decrement cnt each cycle. At cnt = 0, go to CAPTURE.
- CAPTURE, cycle T+1+RD_LAT: register mem_rdata into x_rdata and set x_rvalid = 1 for the next cycle; go to IDLE.
  - With RD_LAT = 1, rvalid is high in cycle T+3.
  - rvalid and the next arbitration cycle may coincide.
- Throughput:
  - Write occupies 2 cycles (IDLE+ISSUE).
  - Read occupies RD_LAT+2 cycles.
- Requester rules:
  - req may drop only in the cycle after gnt. req still high in that cycle is a new request.
  - The arbiter never samples req outside IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate A,B,A,B. No requester waits more than one foreign access.
- Simultaneous events:
  - rvalid for one requester and gnt for the other may be high in the same cycle.
  - rvalid and gnt for the same requester may also coincide, from a back-to-back request.
- mem_addr/mem_wdata hold their last value when idle. mem_we is high only in ISSUE.
- Reset mid-operation: everything returns to reset values immediately.
  - An in-flight read produces no rvalid.
  - An in-flight write may or may not have been sampled by the RAM.
- Address wrap: none. The full AW range is passed through unchanged.

Decomposition:
- Package pi_mem_pkg:
  - typedef arb_state_t {IDLE, ISSUE, RWAIT, CAPTURE}
  - typedef req_id_t {REQ_A, REQ_B}
  - constants MEM_AW = 7, MEM_DW = 32.
- Natural sub-module: rr_arb2, the 2-way round-robin selector holding `last` (inputs req[1:0]/accept, output winner/valid). Everything else stays in pi_mem_arbiter.

Test Plan:
- A write 0x12345678 to addr 5, B idle:
  - a_gnt high at T+1, same cycle as mem_we = 1 and mem_addr = 5.
  - Next arbitration at T+2.
  - A later A read of addr 5 gives a_rdata = 0x12345678 with a_rvalid at T+3 (RD_LAT = 1).
- A and B both req in the same cycle after reset:
  - A is granted first, B second.
  - With both held continuously for 6 accesses: grant order is A,B,A,B,A,B.
- B read addr 0x7F with RD_LAT = 3:
  - b_rvalid exactly 5 cycles after the IDLE cycle.
  - mem_we = 0 throughout.
  - b_rdata is held after rvalid drops.
- A read immediately followed by B write:
  - a_rvalid and b_gnt may both be high in the same cycle.
  - The B write does not corrupt a_rdata.
- iRSTN asserted during RWAIT:
  - All outputs are 0 asynchronously. No rvalid follows.
  - After release, a tie goes to A.
- req toggled while busy:
  - The arbiter does not react until IDLE.
  - A request raised and dropped during ISSUE is never granted.

Source files
------------

// File: rtl/pi_mem_pkg.sv
// Shared types and sizes for the Pi/Nios mailbox RAM port arbiter.
package pi_mem_pkg;

  localparam int MEM_AW = 7;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, CAPTURE} arb_state_t;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; remembers the last accepted requester so that
// a tie goes to the other one.
module rr_arb2
  import pi_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output req_id_t    winner,
  output logic       valid
);

  req_id_t last_q, last_d;

  always_comb begin
    valid  = |req;
    winner = REQ_A;
    case (req)
      2'b10:   winner = REQ_B;
      2'b11:   winner = (last_q == REQ_A) ? REQ_B : REQ_A;
      default: winner = REQ_A;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept && valid) last_d = winner;
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/pi_mem_arbiter.sv
// Shares the s2 port of the Nios/Pi mailbox RAM between the SPI bridge (A) and
// FPGA-side logic (B): round-robin, one access in flight, registered outputs.
module pi_mem_arbiter
  import pi_mem_pkg::*;
#(
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW,
  parameter int RD_LAT = 1
)(
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CNT_W = 2;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_t          owner_q, owner_d;
  logic             rd_q, rd_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic             busy_q, busy_d;

  logic    arb_valid;
  logic    accept;
  req_id_t arb_winner;

  // Requests are only looked at while idle.
  assign accept = (state_q == IDLE) && arb_valid;

  rr_arb2 u_rr_arb2 (
    .clk    (iCLK),
    .rst_n  (iRSTN),
    .req    ({b_req, a_req}),
    .accept (accept),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = ISSUE;
      ISSUE: begin
        if (!rd_q)            state_d = IDLE;
        else if (RD_LAT == 1) state_d = CAPTURE;
        else begin
          state_d = RWAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      // Leave when the count reaches zero so CAPTURE lands RD_LAT cycles after ISSUE.
      RWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    busy_d      = (state_d != IDLE);
    if (accept) begin
      owner_d = arb_winner;
      if (arb_winner == REQ_A) begin
        mem_addr_d  = a_addr;
        mem_wdata_d = a_wdata;
        mem_we_d    = a_we;
        rd_d        = !a_we;
        a_gnt_d     = 1'b1;
      end else begin
        mem_addr_d  = b_addr;
        mem_wdata_d = b_wdata;
        mem_we_d    = b_we;
        rd_d        = !b_we;
        b_gnt_d     = 1'b1;
      end
    end
    if (state_q == CAPTURE) begin
      if (owner_q == REQ_A) begin
        a_rdata_d  = mem_rdata;
        a_rvalid_d = 1'b1;
      end else begin
        b_rdata_d  = mem_rdata;
        b_rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= REQ_A;
      rd_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      rd_q        <= rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pi_mem_arbiter.sv
// Bench for pi_mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each attached to a behavioural RAM of matching latency.
module tb_pi_mem_arbiter;
  import pi_mem_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n3, ram_init;

  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, busy;

  logic          a_req3, a_we3, b_req3, b_we3;
  logic [AW-1:0] a_addr3, b_addr3, mem_addr3;
  logic [DW-1:0] a_wdata3, b_wdata3, a_rdata3, b_rdata3, mem_wdata3, mem_rdata3;
  logic          a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, mem_we3, busy3;

  pi_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .iCLK(clk), .iRSTN(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  pi_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
    .iCLK(clk), .iRSTN(rst_n3),
    .a_req(a_req3), .a_we(a_we3), .a_addr(a_addr3), .a_wdata(a_wdata3),
    .a_gnt(a_gnt3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
    .b_req(b_req3), .b_we(b_we3), .b_addr(b_addr3), .b_wdata(b_wdata3),
    .b_gnt(b_gnt3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return {8'hA5, 8'(i), 16'(i * 3 + 1)};
  endfunction

  logic [DW-1:0] ram1 [0:127];
  logic [DW-1:0] ram3 [0:127];
  logic [DW-1:0] p1_3, p2_3;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) begin
        ram1[i] <= pat(i);
        ram3[i] <= pat(i);
      end
    end else begin
      if (mem_we)  ram1[mem_addr]  <= mem_wdata;
      if (mem_we3) ram3[mem_addr3] <= mem_wdata3;
    end
    mem_rdata  <= ram1[mem_addr];
    p1_3       <= ram3[mem_addr3];
    p2_3       <= p1_3;
    mem_rdata3 <= p2_3;
  end

  int n_chk  = 0;
  int n_pass = 0;
  grant_t        gq[$];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] sh1 [0:127];
  vec_t          tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input bit id, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (!id) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
    else     begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
  endtask

  task automatic push_gnt(input bit id, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
    gq.push_back('{id, we, addr, wd});
    if (we) sh1[addr] = wd;
  endtask

  task automatic push_rd(input bit id, input logic [DW-1:0] val);
    if (id) qb.push_back(val);
    else    qa.push_back(val);
  endtask

  // Scoreboard for the RD_LAT=1 instance: every grant and read return is matched
  // against what the stimulus queued.
  task automatic monitor();
    grant_t        g;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (a_gnt || b_gnt) begin
          chk("gnt_onehot", {a_gnt, b_gnt} == 2'b11, 0);
          chk("gnt_expected", gq.size() != 0, 1);
          if (gq.size() != 0) begin
            g = gq.pop_front();
            chk("gnt_id", b_gnt, g.id);
            chk("gnt_mem_we", mem_we, g.we);
            chk("gnt_mem_addr", mem_addr, g.addr);
            if (g.we) chk("gnt_mem_wdata", mem_wdata, g.wdata);
            chk("gnt_busy", busy, 1);
          end
        end else begin
          chk("we_outside_issue", mem_we, 0);
        end
        if (a_rvalid) begin
          chk("a_rvalid_expected", qa.size() != 0, 1);
          if (qa.size() != 0) begin e = qa.pop_front(); chk("a_rdata", a_rdata, e); end
        end
        if (b_rvalid) begin
          chk("b_rvalid_expected", qb.size() != 0, 1);
          if (qb.size() != 0) begin e = qb.pop_front(); chk("b_rdata", b_rdata, e); end
        end
      end
    end
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    push_gnt(v.id, v.we, v.addr, v.wdata);
    if (!v.we) push_rd(v.id, v.exp);
    n = 0;
    do begin @(negedge clk); n++; end while (!(v.id ? b_gnt : a_gnt) && n < 8);
    chk("txn_gnt_latency", n, 1);
    drive(v.id, 1'b0, v.we, v.addr, v.wdata);
    if (!v.we) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(v.id ? b_rvalid : a_rvalid) && n < 8);
      chk("txn_rvalid_latency", n, 2);
    end else begin
      @(negedge clk);
      chk("txn_write_idle", busy, 0);
    end
  endtask

  task automatic run();
    logic [1:0] eg;
    rst_n = 1'b0; rst_n3 = 1'b0; ram_init = 1'b1;
    drive(0, 0, 0, '0, '0); drive(1, 0, 0, '0, '0);
    a_req3 = 0; a_we3 = 0; a_addr3 = '0; a_wdata3 = '0;
    b_req3 = 0; b_we3 = 0; b_addr3 = '0; b_wdata3 = '0;
    for (int i = 0; i < 128; i++) sh1[i] = pat(i);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, busy}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", a_rdata | b_rdata, 0);
    ram_init = 1'b0; rst_n = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);

    // A write, then B read of the same word raised during ISSUE.
    drive(0, 1, 1, 7'h05, 32'h12345678); push_gnt(0, 1, 7'h05, 32'h12345678);
    @(negedge clk);
    chk("wr_a_gnt", a_gnt, 1);
    drive(0, 0, 1, 7'h05, 32'h12345678);
    drive(1, 1, 0, 7'h05, '0); push_gnt(1, 0, 7'h05, '0); push_rd(1, 32'h12345678);
    @(negedge clk);
    chk("wr_idle_t2", {b_gnt, busy}, 0);
    @(negedge clk);
    chk("next_arb_b_gnt", b_gnt, 1);
    drive(1, 0, 0, 7'h05, '0);
    @(negedge clk);
    chk("rd_b_rvalid_early", b_rvalid, 0);
    @(negedge clk);
    chk("rd_b_rvalid", b_rvalid, 1);

    tbl[0] = '{1'b0, 1'b0, 7'h05, 32'h0, 32'h12345678};
    tbl[1] = '{1'b1, 1'b1, 7'h7F, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 7'h7F, 32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 7'h00, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 7'h00, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 7'h03, 32'h0, pat(3)};
    tbl[6] = '{1'b0, 1'b1, 7'h40, 32'hFFFFFFFF, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 7'h40, 32'h0, 32'hFFFFFFFF};
    tbl[8] = '{1'b0, 1'b0, 7'h7F, 32'h0, 32'hDEADBEEF};
    tbl[9] = '{1'b1, 1'b1, 7'h2A, 32'h0F0F0F0F, 32'h0};
    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // Both requesters hold writes continuously: grants must alternate A,B,...
    drive(0, 1, 1, 7'h0A, 32'h0A0A0A0A);
    drive(1, 1, 1, 7'h0B, 32'h0B0B0B0B);
    for (int k = 0; k < 3; k++) begin
      push_gnt(0, 1, 7'h0A, 32'h0A0A0A0A);
      push_gnt(1, 1, 7'h0B, 32'h0B0B0B0B);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      eg = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b10 : 2'b01);
      chk("fair_order", {a_gnt, b_gnt}, eg);
      if (i == 11) begin a_req = 0; b_req = 0; end
    end

    // A read followed by a B write to the same word.
    drive(0, 1, 0, 7'h05, '0); push_gnt(0, 0, 7'h05, '0); push_rd(0, 32'h12345678);
    @(negedge clk);
    chk("rdwr_a_gnt", a_gnt, 1);
    drive(0, 0, 0, 7'h05, '0);
    drive(1, 1, 1, 7'h05, 32'hCAFEF00D); push_gnt(1, 1, 7'h05, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    chk("rdwr_a_rvalid", {a_rvalid, b_gnt}, 2'b10);
    @(negedge clk);
    chk("rdwr_b_gnt", b_gnt, 1);
    drive(1, 0, 1, 7'h05, 32'hCAFEF00D);
    @(negedge clk);
    chk("rdwr_a_rdata_kept", a_rdata, 32'h12345678);

    // Requests toggled while busy.
    drive(0, 1, 0, 7'h40, '0); push_gnt(0, 0, 7'h40, '0); push_rd(0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("tog_a_gnt", a_gnt, 1);
    drive(0, 0, 0, 7'h40, '0);
    drive(1, 1, 1, 7'h01, 32'h00000001);
    #2;
    b_req = 1'b0;
    @(negedge clk);
    drive(1, 1, 1, 7'h02, 32'h00000022); push_gnt(1, 1, 7'h02, 32'h00000022);
    @(negedge clk);
    chk("tog_no_early_gnt", {a_rvalid, b_gnt}, 2'b10);
    @(negedge clk);
    chk("tog_b_gnt_idle", b_gnt, 1);
    drive(1, 0, 1, 7'h02, 32'h00000022);
    @(negedge clk);
    do_txn('{1'b0, 1'b0, 7'h01, 32'h0, pat(1)});
    do_txn('{1'b1, 1'b0, 7'h02, 32'h0, 32'h00000022});

    // RD_LAT=3 instance: B read of the top word.
    b_req3 = 1; b_we3 = 0; b_addr3 = 7'h7F;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin chk("l3_b_gnt", b_gnt3, 1); b_req3 = 0; end
      chk("l3_mem_we", mem_we3, 0);
      chk("l3_b_rvalid", b_rvalid3, (i == 5));
      if (i <= 5) chk("l3_busy", busy3, (i <= 4));
      if (i >= 5) chk("l3_b_rdata", b_rdata3, pat(127));
    end

    // Reset asserted while the RD_LAT=3 instance waits on a read.
    a_req3 = 1; a_we3 = 0; a_addr3 = 7'h10;
    @(negedge clk);
    chk("l3_a_gnt", a_gnt3, 1);
    a_req3 = 0;
    @(negedge clk);
    chk("l3_busy_rwait", busy3, 1);
    #1 rst_n3 = 1'b0;
    #1;
    chk("l3_rst_ctrl", {a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, mem_we3, busy3}, 0);
    chk("l3_rst_addr", mem_addr3, 0);
    chk("l3_rst_rdata", a_rdata3 | b_rdata3 | mem_wdata3, 0);
    @(negedge clk);
    rst_n3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l3_no_rvalid", {a_rvalid3, b_rvalid3, busy3}, 0);
    end
    a_req3 = 1; a_we3 = 1; a_addr3 = 7'h03; a_wdata3 = 32'h33;
    b_req3 = 1; b_we3 = 1; b_addr3 = 7'h04; b_wdata3 = 32'h44;
    @(negedge clk);
    chk("l3_tie_a_first", {a_gnt3, b_gnt3}, 2'b10);
    chk("l3_tie_addr", mem_addr3, 7'h03);
    a_req3 = 0;
    @(negedge clk);
    chk("l3_tie_gap", {a_gnt3, b_gnt3}, 2'b00);
    @(negedge clk);
    chk("l3_tie_b_second", {a_gnt3, b_gnt3}, 2'b01);
    b_req3 = 0;
    repeat (4) @(negedge clk);

    chk("gq_drained", gq.size(), 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  initial begin
    fork
      monitor();
    join_none
    run();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
